// File: rtl/mult_share_arbiter_pkg.sv
// mult_share_arbiter_pkg: shared states, operand/product widths and tag-width helper
package mult_share_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, MUL, RESP} state_e;
   localparam int OP_W   = 4;
   localparam int PROD_W = 8;
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mult_share_arbiter_mul4x4.sv
// mult_share_arbiter_mul4x4: combinational unsigned 4x4 array multiplier core
module mult_share_arbiter_mul4x4
   import mult_share_arbiter_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] p
);
   always_comb begin
      p = '0;
      for (int i = 0; i < OP_W; i++)
         p = p + (PROD_W'(a & {OP_W{b[i]}}) << i);
   end
endmodule

// File: rtl/mult_share_arbiter_rr_picker.sv
// mult_share_arbiter_rr_picker: first set request searching upward from ptr+1, wrapping
module mult_share_arbiter_rr_picker #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] idx,
   output logic            any_req
);
   int j;
   always_comb begin
      gnt     = '0;
      idx     = '0;
      any_req = 1'b0;
      j       = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any_req && req[j]) begin
            any_req = 1'b1;
            gnt[j]  = 1'b1;
            idx     = ID_W'(j);
         end
      end
   end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 4x4 multiplier among NUM_REQ
// requesters, returning tagged products on one backpressured response channel.
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ),
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [OP_W*NUM_REQ-1:0] req_a,
   input  logic [OP_W*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [PROD_W-1:0]       rsp_product,
   output logic                    busy,
   output logic [CNT_W-1:0]        done_count
);
   state_e              state_q;
   logic [OP_W-1:0]     a_q, b_q;
   logic [ID_W-1:0]     id_q, rr_q, gnt_idx;
   logic [NUM_REQ-1:0]  gnt;
   logic                any_req;
   logic [PROD_W-1:0]   prod;
   mult_share_arbiter_rr_picker #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req(req_valid), .ptr(rr_q), .gnt(gnt), .idx(gnt_idx), .any_req(any_req)
   );
   mult_share_arbiter_mul4x4 u_mul (.a(a_q), .b(b_q), .p(prod));
   assign req_ready = (state_q == IDLE) ? gnt : '0;
   assign busy      = state_q != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rr_q        <= ID_W'(NUM_REQ - 1);
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_product <= '0;
         done_count  <= '0;
      end else begin
         case (state_q)
            IDLE: if (any_req) begin
               a_q     <= req_a[int'(gnt_idx)*OP_W +: OP_W];
               b_q     <= req_b[int'(gnt_idx)*OP_W +: OP_W];
               id_q    <= gnt_idx;
               rr_q    <= gnt_idx;
               state_q <= MUL;
            end
            MUL: begin
               rsp_product <= prod;
               rsp_id      <= id_q;
               rsp_valid   <= 1'b1;
               state_q     <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid  <= 1'b0;
               done_count <= done_count + 1'b1;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed vectors with hand-computed products, tags and counts
module tb_mult_share_arbiter;
   localparam int N = 4;
   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req_valid, req_ready;
   logic [15:0]  req_a, req_b;
   logic         rsp_valid, rsp_ready, busy;
   logic [1:0]   rsp_id;
   logic [7:0]   rsp_product;
   logic [3:0]   done_count, exp_cnt;
   int total = 0, bad = 0;

   mult_share_arbiter #(.NUM_REQ(N), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy), .done_count(done_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
      req_a[4*i +: 4] = a;
      req_b[4*i +: 4] = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_cnt = '0;
   endtask

   // Assumes IDLE with inputs set and rsp_ready=1; scram flips all operands after accept
   task automatic run_one(input int id, input int prod, input bit scram);
      logic [15:0] sa, sb;
      #1;
      chk("grant", 32'(req_ready), 32'(1 << id));
      tick();
      chk("ready_low_in_mul", 32'(req_ready), 0);
      chk("busy_in_mul", 32'(busy), 1);
      sa = req_a;
      sb = req_b;
      if (scram) begin
         req_a = ~req_a;
         req_b = ~req_b;
      end
      tick();
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), 32'(id));
      chk("rsp_product", 32'(rsp_product), 32'(prod));
      req_a = sa;
      req_b = sb;
      tick();
      exp_cnt++;
      chk("rsp_valid_after_hs", 32'(rsp_valid), 0);
      chk("done_count", 32'(done_count), 32'(exp_cnt));
   endtask

   initial begin
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      do_reset();
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done_count), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_product", 32'(rsp_product), 0);

      // Single request from requester 2, with requester 0 operands wiggling unused
      set_op(2, 4'd7, 4'd9);
      req_valid = 4'b0100;
      set_op(0, 4'd3, 4'd3);
      run_one(2, 63, 1'b1);
      req_valid = '0;
      set_op(2, 4'd0, 4'd0);

      // Request withdrawn before any edge: no grant, stay idle
      req_valid = 4'b1000;
      #1;
      req_valid = '0;
      tick();
      chk("withdrawn_busy", 32'(busy), 0);

      // All four valid after reset: strict rotation 0,1,2,3
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, 4'(i + 1), 4'(i + 2));
      req_valid = 4'b1111;
      run_one(0, 2, 1'b0);
      run_one(1, 6, 1'b0);
      run_one(2, 12, 1'b0);
      run_one(3, 20, 1'b0);
      run_one(0, 2, 1'b0);
      req_valid = '0;

      // Extremes from a lone requester 1, granted every time
      req_valid = 4'b0010;
      set_op(1, 4'd15, 4'd15);
      run_one(1, 225, 1'b1);
      set_op(1, 4'd0, 4'd13);
      run_one(1, 0, 1'b0);
      set_op(1, 4'd1, 4'd11);
      run_one(1, 11, 1'b0);

      // Backpressure: rr_ptr=1, so requester 0 wins, then requester 1
      set_op(0, 4'd3, 4'd5);
      set_op(1, 4'd2, 4'd6);
      req_valid = 4'b0011;
      rsp_ready = 1'b0;
      #1;
      chk("bp_grant", 32'(req_ready), 32'b0001);
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_product", 32'(rsp_product), 15);
         chk("bp_id", 32'(rsp_id), 0);
         chk("bp_ready", 32'(req_ready), 0);
         chk("bp_done", 32'(done_count), 32'(exp_cnt));
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      exp_cnt++;
      chk("bp_done_inc", 32'(done_count), 32'(exp_cnt));
      chk("bp_busy", 32'(busy), 0);
      run_one(1, 12, 1'b0);
      req_valid = '0;

      // Reset while in MUL drops the transaction
      set_op(2, 4'd5, 4'd5);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      chk("pre_rst_busy", 32'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_cnt = '0;
      chk("mid_rst_valid", 32'(rsp_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done_count), 0);
      set_op(0, 4'd4, 4'd4);
      set_op(3, 4'd6, 4'd7);
      req_valid = 4'b1001;
      run_one(0, 16, 1'b0);
      run_one(3, 42, 1'b0);
      req_valid = '0;

      // Counter wrap: 16 handshakes after reset bring done_count back to 0
      do_reset();
      set_op(1, 4'd2, 4'd3);
      req_valid = 4'b0010;
      for (int t = 0; t < 16; t++) run_one(1, 6, 1'b0);
      chk("wrap_zero", 32'(done_count), 0);
      req_valid = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
